life_mem_arbiter: RTL and testbench

LIFE_MEM_ARBITER -- requirements
Module: life_mem_arbiter

---
 rtl/life_mem_arbiter.sv | 66 ++++++
 tb/tb_life_mem_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/life_mem_arbiter.sv
// life_mem_arbiter: single-port board RAM arbiter (display > update/write round-robin) with starvation flags.
module life_mem_arbiter #(
  parameter int ADDR_W       = 9,
  parameter int STARVE_LIMIT = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_rdata,
  output logic              disp_rvalid,
  input  logic              upd_req,
  input  logic [ADDR_W-1:0] upd_addr,
  output logic              upd_gnt,
  output logic              upd_rdata,
  output logic              upd_rvalid,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_data,
  output logic              wr_gnt,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wdata,
  input  logic              mem_rdata,
  output logic [1:0]        starve
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
  logic last_wr, tag_disp, tag_upd, pick_wr;
  logic [1:0] starve_q;
  logic [CW-1:0] wait_upd, wait_wr, next_upd, next_wr;
  always_comb begin
    pick_wr = wr_req & (~upd_req | ~last_wr);
    upd_gnt = ~reset & ~disp_req & upd_req & ~pick_wr;
    wr_gnt = ~reset & ~disp_req & pick_wr;
    mem_en = ~reset & (disp_req | upd_req | wr_req);
    mem_we = wr_gnt;
    mem_addr = reset ? '0 : disp_req ? disp_addr : upd_gnt ? upd_addr : wr_gnt ? wr_addr : '0;
    mem_wdata = wr_gnt & wr_data;
    next_upd = (upd_req & ~upd_gnt) ? (wait_upd == LIM ? LIM : wait_upd + CW'(1)) : '0;
    next_wr = (wr_req & ~wr_gnt) ? (wait_wr == LIM ? LIM : wait_wr + CW'(1)) : '0;
    disp_rvalid = tag_disp & ~reset;
    upd_rvalid = tag_upd & ~reset;
    disp_rdata = disp_rvalid & mem_rdata;
    upd_rdata = upd_rvalid & mem_rdata;
    starve = reset ? 2'b00 : starve_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      last_wr <= 1'b1;
      tag_disp <= 1'b0;
      tag_upd <= 1'b0;
      wait_upd <= '0;
      wait_wr <= '0;
      starve_q <= 2'b00;
    end else begin
      if (upd_gnt | wr_gnt) last_wr <= wr_gnt;
      tag_disp <= disp_req;
      tag_upd <= upd_gnt;
      wait_upd <= next_upd;
      wait_wr <= next_wr;
      starve_q <= {next_wr == LIM, next_upd == LIM};
    end
  end
endmodule

// File: tb/tb_life_mem_arbiter.sv
// tb_life_mem_arbiter: randomized + directed checks of life_mem_arbiter against a behavioural model.
module tb_life_mem_arbiter;
  localparam int AW = 9;
  localparam int LIM = 15;
  logic clk = 0, reset = 1;
  logic disp_req = 0, upd_req = 0, wr_req = 0, wr_data = 0;
  logic [AW-1:0] disp_addr = 0, upd_addr = 0, wr_addr = 0;
  logic disp_rdata, disp_rvalid, upd_gnt, upd_rdata, upd_rvalid, wr_gnt;
  logic mem_en, mem_we, mem_wdata, mem_rdata = 0;
  logic [AW-1:0] mem_addr;
  logic [1:0] starve;
  int vecs = 0, errs = 0;

  life_mem_arbiter #(.ADDR_W(AW), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid),
    .upd_req(upd_req), .upd_addr(upd_addr), .upd_gnt(upd_gnt), .upd_rdata(upd_rdata), .upd_rvalid(upd_rvalid),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .starve(starve)
  );

  always #5 clk = ~clk;

  // board RAM: synchronous read, one access per cycle
  bit ram [512];
  always @(posedge clk)
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else mem_rdata <= ram[mem_addr];
    end

  // behavioural model state
  bit shadow [512];
  int m_last_wr = 1, m_wu = 0, m_ww = 0;
  bit m_pend_d = 0, m_pend_u = 0, m_pend_data = 0;
  bit e_ug, e_wg, e_en;
  int e_addr;

  task automatic check(string name, int act, int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic predict();
    e_ug = 0; e_wg = 0; e_en = 0; e_addr = 0;
    if (!reset) begin
      if (disp_req) begin
        e_en = 1; e_addr = int'(disp_addr);
      end else if (upd_req && wr_req) begin
        if (m_last_wr == 1) e_ug = 1; else e_wg = 1;
      end else if (upd_req) e_ug = 1;
      else if (wr_req) e_wg = 1;
      if (e_ug) begin e_en = 1; e_addr = int'(upd_addr); end
      if (e_wg) begin e_en = 1; e_addr = int'(wr_addr); end
    end
  endtask

  always @(posedge clk) begin
    predict();
    if (reset) begin
      m_last_wr = 1; m_wu = 0; m_ww = 0; m_pend_d = 0; m_pend_u = 0;
    end else begin
      m_pend_d = disp_req;
      m_pend_u = e_ug;
      if (disp_req) m_pend_data = shadow[disp_addr];
      else if (e_ug) m_pend_data = shadow[upd_addr];
      if (e_wg) begin shadow[wr_addr] = wr_data; m_last_wr = 1; end
      if (e_ug) m_last_wr = 0;
      m_wu = (upd_req && !e_ug) ? ((m_wu + 1 > LIM) ? LIM : m_wu + 1) : 0;
      m_ww = (wr_req && !e_wg) ? ((m_ww + 1 > LIM) ? LIM : m_ww + 1) : 0;
    end
  end

  always @(negedge clk) begin
    bit dv, uv;
    predict();
    dv = !reset && m_pend_d;
    uv = !reset && m_pend_u;
    check("upd_gnt", upd_gnt, e_ug);
    check("wr_gnt", wr_gnt, e_wg);
    check("mem_en", mem_en, e_en);
    check("mem_we", mem_we, e_wg);
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wg ? wr_data : 0);
    check("disp_rvalid", disp_rvalid, dv);
    check("disp_rdata", disp_rdata, dv ? m_pend_data : 0);
    check("upd_rvalid", upd_rvalid, uv);
    check("upd_rdata", upd_rdata, uv ? m_pend_data : 0);
    check("starve", starve, reset ? 0 : {m_ww == LIM, m_wu == LIM});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    disp_req = 0; upd_req = 0; wr_req = 0;
  endtask

  initial begin
    bit ug, wg;
    repeat (3) tick();
    @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_starve", starve, 0);
    tick();
    reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_mem_en", mem_en, 0);
      check("idle_rvalid", {disp_rvalid, upd_rvalid}, 0);
      check("idle_starve", starve, 0);
      tick();
    end
    upd_req = 1; upd_addr = 5;
    @(negedge clk);
    check("rd5_gnt", upd_gnt, 1);
    check("rd5_addr", mem_addr, 5);
    check("rd5_we", mem_we, 0);
    tick();
    upd_req = 0;
    @(negedge clk);
    check("rd5_rvalid", upd_rvalid, 1);
    check("rd5_rdata", upd_rdata, 0);
    tick();
    wr_req = 1; wr_addr = 7; wr_data = 1;
    @(negedge clk);
    check("wr7_gnt", wr_gnt, 1);
    check("wr7_we", mem_we, 1);
    check("wr7_addr", mem_addr, 7);
    tick();
    wr_req = 0; upd_req = 1; upd_addr = 7;
    @(negedge clk);
    check("rd7_gnt", upd_gnt, 1);
    tick();
    upd_req = 0;
    @(negedge clk);
    check("rd7_rvalid", upd_rvalid, 1);
    check("rd7_rdata", upd_rdata, 1);
    tick();
    reset = 1;
    tick();
    reset = 0; upd_req = 1; upd_addr = 1; wr_req = 1; wr_addr = 2; wr_data = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("alt_upd_gnt", upd_gnt, (i % 2 == 0) ? 1 : 0);
      check("alt_wr_gnt", wr_gnt, (i % 2 == 1) ? 1 : 0);
      tick();
    end
    idle();
    tick();
    disp_req = 1; disp_addr = 9; upd_req = 1; upd_addr = 4;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      check("starve_upd_gnt", upd_gnt, 0);
      check("starve_bit", starve[0], (i >= 16) ? 1 : 0);
      tick();
    end
    disp_req = 0;
    @(negedge clk);
    check("starve_release_gnt", upd_gnt, 1);
    check("starve_still", starve[0], 1);
    tick();
    upd_req = 0;
    @(negedge clk);
    check("starve_cleared", starve[0], 0);
    tick();
    disp_req = 1; disp_addr = 3;
    @(negedge clk);
    check("disp_issue_en", mem_en, 1);
    check("disp_issue_addr", mem_addr, 3);
    tick();
    disp_req = 0; reset = 1;
    @(negedge clk);
    check("rst_disp_rvalid", disp_rvalid, 0);
    check("rst2_mem_en", mem_en, 0);
    check("rst2_starve", starve, 0);
    tick();
    reset = 0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      ug = upd_gnt; wg = wr_gnt;
      tick();
      reset = ($urandom_range(0, 99) == 0);
      disp_req = ($urandom_range(0, 3) == 0);
      disp_addr = AW'($urandom_range(0, 511));
      if (!(upd_req && !ug && $urandom_range(0, 9) != 0)) begin
        upd_req = $urandom_range(0, 1) == 1;
        upd_addr = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 15) : $urandom_range(0, 511));
      end
      if (!(wr_req && !wg && $urandom_range(0, 9) != 0)) begin
        wr_req = $urandom_range(0, 1) == 1;
        wr_addr = AW'($urandom_range(0, 1) == 1 ? $urandom_range(0, 15) : $urandom_range(0, 511));
        wr_data = $urandom_range(0, 1) == 1;
      end
    end
    idle();
    tick();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
